// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for the branch resolve controller.
// Latency: n/a (declarations only). Backpressure: n/a.
package branch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        REDIR = 2'd2
    } state_t;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    localparam logic [31:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [2:0]  funct3;
        logic [31:0] imm;
    } br_req_t;

    // Only the six branch encodings are legal; 010/011 are reserved.
    function automatic logic funct3_illegal(input logic [2:0] f3);
        logic bad;
        bad = 1'b1;
        case (f3)
            BEQ, BNE, BLT, BGE, BLTU, BGEU: bad = 1'b0;
            default:                        bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl.sv
// Resolves one branch per request via an external comparator; BRANCH_BTFN_PRED_EN selects BTFN prediction.
// Latency: accept at edge N -> done/redir_valid after edge N+1; 1 request per 2 cycles without redirect.
// Backpressure: req_ready low outside IDLE; redirect held stable until redir_ready.
module branch_resolve_ctrl
    import branch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_pc,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_imm,
    output logic [31:0] cmp_op1,
    output logic [31:0] cmp_op2,
    output logic [2:0]  cmp_funct3,
    input  logic        cmp_branch,
    output logic        redir_valid,
    input  logic        redir_ready,
    output logic [31:0] redir_pc,
    output logic        flush,
    output logic        done,
    output logic        done_taken,
    output logic        misalign,
    output logic        illegal,
    output logic [15:0] mispredict_cnt
);

    state_t      state_q;
    state_t      state_d;
    br_req_t     req_q;

    logic        in_eval;
    logic        taken;
    logic        need_redir;
    logic        bad_f3;
    logic        bad_align;
    logic        eval_ok;
    logic        redir_hs;
    logic [31:0] target;
    logic [31:0] fallthru;

    logic [31:0] redir_pc_q;
    logic        flush_q;
    logic        done_q;
    logic        done_taken_q;
    logic        misalign_q;
    logic        illegal_q;
    logic [15:0] cnt_q;

    // Captured registers feed the comparator directly: they only change on
    // accept, so they hold the last evaluated operands in IDLE and REDIR.
    assign cmp_op1    = req_q.op1;
    assign cmp_op2    = req_q.op2;
    assign cmp_funct3 = req_q.funct3;

    assign in_eval  = (state_q == EVAL);
    assign taken    = cmp_branch;
    assign target   = req_q.pc + req_q.imm;
    assign fallthru = req_q.pc + PC_INC;
    assign bad_f3   = funct3_illegal(req_q.funct3);

`ifdef BRANCH_BTFN_PRED_EN
    logic predicted;
    assign predicted  = req_q.imm[31];
    assign need_redir = (taken != predicted);
`else
    assign need_redir = taken;
`endif

    assign bad_align = need_redir && taken && (target[1:0] != 2'b00);
    assign eval_ok   = !bad_f3 && !bad_align;
    assign redir_hs  = redir_valid && redir_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid)          state_d = EVAL;
            EVAL:    if (eval_ok && need_redir) state_d = REDIR;
                     else                     state_d = IDLE;
            REDIR:   if (redir_ready)        state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        req_ready   = 1'b0;
        redir_valid = 1'b0;
        case (state_q)
            IDLE:    req_ready   = 1'b1;
            REDIR:   redir_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q        <= '0;
            redir_pc_q   <= '0;
            flush_q      <= 1'b0;
            done_q       <= 1'b0;
            done_taken_q <= 1'b0;
            misalign_q   <= 1'b0;
            illegal_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            if (req_valid && req_ready) begin
                req_q.pc     <= req_pc;
                req_q.op1    <= req_op1;
                req_q.op2    <= req_op2;
                req_q.funct3 <= req_funct3;
                req_q.imm    <= req_imm;
            end
            done_q       <= in_eval && eval_ok;
            done_taken_q <= in_eval && eval_ok && taken;
            misalign_q   <= in_eval && !bad_f3 && bad_align;
            illegal_q    <= in_eval && bad_f3;
            if (in_eval && eval_ok && need_redir) begin
                redir_pc_q <= taken ? target : fallthru;
            end
            // Flush lands in the cycle after the redirect is accepted.
            flush_q <= redir_hs;
            if (redir_hs && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign redir_pc       = redir_pc_q;
    assign flush          = flush_q;
    assign done           = done_q;
    assign done_taken     = done_taken_q;
    assign misalign       = misalign_q;
    assign illegal        = illegal_q;
    assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed vector bench for branch_resolve_ctrl; expectations follow the BRANCH_BTFN_PRED_EN build setting.
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc, req_op1, req_op2, req_imm;
    logic [2:0]  req_funct3;
    logic [31:0] cmp_op1, cmp_op2;
    logic [2:0]  cmp_funct3;
    logic        cmp_branch;
    logic        redir_valid, redir_ready;
    logic [31:0] redir_pc;
    logic        flush, done, done_taken, misalign, illegal;
    logic [15:0] mispredict_cnt;

    int tests  = 0;
    int failed = 0;
    logic [15:0] exp_cnt = 16'd0;

    branch_resolve_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_pc(req_pc), .req_op1(req_op1), .req_op2(req_op2),
        .req_funct3(req_funct3), .req_imm(req_imm),
        .cmp_op1(cmp_op1), .cmp_op2(cmp_op2), .cmp_funct3(cmp_funct3),
        .cmp_branch(cmp_branch),
        .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
        .flush(flush), .done(done), .done_taken(done_taken),
        .misalign(misalign), .illegal(illegal), .mispredict_cnt(mispredict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, op1, op2;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic        br;
        logic        e_done, e_taken, e_redir, e_mis, e_ill;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    function automatic vec_t mkv(input logic [31:0] pc, op1, op2, input logic [2:0] f3,
                                 input logic [31:0] imm, input logic br,
                                 input logic d, t, r, m, il, input logic [31:0] epc);
        vec_t v;
        v.pc = pc; v.op1 = op1; v.op2 = op2; v.f3 = f3; v.imm = imm; v.br = br;
        v.e_done = d; v.e_taken = t; v.e_redir = r; v.e_mis = m; v.e_ill = il; v.e_pc = epc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        req_pc = v.pc; req_op1 = v.op1; req_op2 = v.op2;
        req_funct3 = v.f3; req_imm = v.imm; cmp_branch = v.br;
        req_valid = 1'b1;
        chk($sformatf("v%0d req_ready idle", idx), {31'b0, req_ready}, 32'd1);
        cyc();
        req_valid = 1'b0;
        chk($sformatf("v%0d req_ready eval", idx), {31'b0, req_ready}, 32'd0);
        chk($sformatf("v%0d cmp_op1", idx), cmp_op1, v.op1);
        chk($sformatf("v%0d cmp_op2", idx), cmp_op2, v.op2);
        chk($sformatf("v%0d cmp_funct3", idx), {29'b0, cmp_funct3}, {29'b0, v.f3});
        cyc();
        chk($sformatf("v%0d done", idx), {31'b0, done}, {31'b0, v.e_done});
        chk($sformatf("v%0d done_taken", idx), {31'b0, done_taken}, {31'b0, v.e_taken});
        chk($sformatf("v%0d misalign", idx), {31'b0, misalign}, {31'b0, v.e_mis});
        chk($sformatf("v%0d illegal", idx), {31'b0, illegal}, {31'b0, v.e_ill});
        chk($sformatf("v%0d redir_valid", idx), {31'b0, redir_valid}, {31'b0, v.e_redir});
        if (v.e_redir) begin
            chk($sformatf("v%0d redir_pc", idx), redir_pc, v.e_pc);
            redir_ready = 1'b1;
            cyc();
            redir_ready = 1'b0;
            if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
            chk($sformatf("v%0d flush", idx), {31'b0, flush}, 32'd1);
            chk($sformatf("v%0d cnt", idx), {16'b0, mispredict_cnt}, {16'b0, exp_cnt});
            chk($sformatf("v%0d done cleared", idx), {31'b0, done}, 32'd0);
            cyc();
            chk($sformatf("v%0d flush single", idx), {31'b0, flush}, 32'd0);
            chk($sformatf("v%0d idle after redir", idx), {31'b0, req_ready}, 32'd1);
        end else begin
            chk($sformatf("v%0d idle after eval", idx), {31'b0, req_ready}, 32'd1);
            chk($sformatf("v%0d flush none", idx), {31'b0, flush}, 32'd0);
            chk($sformatf("v%0d cnt", idx), {16'b0, mispredict_cnt}, {16'b0, exp_cnt});
        end
    endtask

    initial begin
        int hs;
        int ncyc;
        bit midchk;

        //             pc            op1    op2    f3      imm           br  dn tk rd ms il  redir_pc
        vecs[0] = mkv(32'h100,      5,     5,     3'b000, 32'h20,       1, 1, 1, 1, 0, 0, 32'h120);
        vecs[1] = mkv(32'h300,      7,     7,     3'b001, 32'h40,       0, 1, 0, 0, 0, 0, 32'h0);
`ifdef BRANCH_BTFN_PRED_EN
        vecs[2] = mkv(32'h200,      3,     9,     3'b100, 32'hFFFFFFF0, 0, 1, 0, 1, 0, 0, 32'h204);
        vecs[3] = mkv(32'h200,      9,     3,     3'b100, 32'hFFFFFFF0, 1, 1, 1, 0, 0, 0, 32'h0);
        vecs[8] = mkv(32'hFFFFFFFC, 1,     2,     3'b101, 32'hFFFFFFF8, 0, 1, 0, 1, 0, 0, 32'h0);
        vecs[9] = mkv(32'h500,      1,     2,     3'b110, 32'hFFFFFFFE, 1, 1, 1, 0, 0, 0, 32'h0);
`else
        vecs[2] = mkv(32'h200,      3,     9,     3'b100, 32'hFFFFFFF0, 0, 1, 0, 0, 0, 0, 32'h0);
        vecs[3] = mkv(32'h200,      9,     3,     3'b100, 32'hFFFFFFF0, 1, 1, 1, 1, 0, 0, 32'h1F0);
        vecs[8] = mkv(32'hFFFFFFFC, 1,     2,     3'b101, 32'hFFFFFFF8, 0, 1, 0, 0, 0, 0, 32'h0);
        vecs[9] = mkv(32'h500,      1,     2,     3'b110, 32'hFFFFFFFE, 1, 0, 0, 0, 1, 0, 32'h0);
`endif
        vecs[4] = mkv(32'h100,      1,     1,     3'b000, 32'h22,       1, 0, 0, 0, 1, 0, 32'h0);
        vecs[5] = mkv(32'h400,      1,     2,     3'b010, 32'h8,        1, 0, 0, 0, 0, 1, 32'h0);
        vecs[6] = mkv(32'h400,      1,     2,     3'b011, 32'h8,        0, 0, 0, 0, 0, 1, 32'h0);
        vecs[7] = mkv(32'hFFFFFFFC, 32'hA, 5,     3'b111, 32'h8,        1, 1, 1, 1, 0, 0, 32'h4);

        rst_n = 1'b0; req_valid = 1'b0; redir_ready = 1'b0; cmp_branch = 1'b0;
        req_pc = '0; req_op1 = '0; req_op2 = '0; req_funct3 = '0; req_imm = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst redir_valid", {31'b0, redir_valid}, 32'd0);
        chk("rst flush", {31'b0, flush}, 32'd0);
        chk("rst done", {31'b0, done}, 32'd0);
        chk("rst redir_pc", redir_pc, 32'd0);
        chk("rst cmp_op1", cmp_op1, 32'd0);
        chk("rst cnt", {16'b0, mispredict_cnt}, 32'd0);

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // Redirect stalled by redir_ready, then abandoned by reset.
        req_pc = 32'h100; req_op1 = 5; req_op2 = 5; req_funct3 = 3'b000;
        req_imm = 32'h20; cmp_branch = 1'b1; req_valid = 1'b1;
        cyc();
        req_valid = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold%0d redir_valid", i), {31'b0, redir_valid}, 32'd1);
            chk($sformatf("hold%0d redir_pc", i), redir_pc, 32'h120);
            chk($sformatf("hold%0d flush", i), {31'b0, flush}, 32'd0);
            cyc();
        end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        exp_cnt = 16'd0;
        chk("mid-redir rst redir_valid", {31'b0, redir_valid}, 32'd0);
        chk("mid-redir rst flush", {31'b0, flush}, 32'd0);
        chk("mid-redir rst cnt", {16'b0, mispredict_cnt}, 32'd0);
        chk("mid-redir rst redir_pc", redir_pc, 32'd0);
        chk("mid-redir rst req_ready", {31'b0, req_ready}, 32'd1);
        cyc();
        chk("mid-redir rst no late flush", {31'b0, flush}, 32'd0);

        // Counter saturation: 0x10001 back-to-back redirects.
        req_pc = 32'h100; req_imm = 32'h20; req_funct3 = 3'b000; cmp_branch = 1'b1;
        req_valid = 1'b1; redir_ready = 1'b1;
        hs = 0; ncyc = 0; midchk = 1'b0;
        while (hs < 32'h10001 && ncyc < 250000) begin
            @(negedge clk);
            ncyc++;
            if (hs == 32'hFFFE && !midchk) begin
                midchk = 1'b1;
                chk("sat near-full cnt", {16'b0, mispredict_cnt}, 32'hFFFE);
            end
            if (redir_valid) hs++;
        end
        req_valid = 1'b0;
        cyc();
        redir_ready = 1'b0;
        chk("sat handshakes in budget", hs, 32'h10001);
        chk("sat cnt", {16'b0, mispredict_cnt}, 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
